audio_serial_tx: RTL
====================

Name: audio_serial_tx

Overview:
- Playback-side serializer that drives the codec DAC with I2S-format serial audio, using one clock domain.
- Pulls one stereo sample pair per frame from the delay buffer's read outputs through a valid/ready handshake.
- Generates bit clock (bclk), word-select (lrclk) and serial data (sdata) from the system clock.
- sample_ready doubles as the per-frame sample strobe for the upstream buffer's write/advance side.

Parameters:
- DATA_WIDTH, 16, bits per channel sample (two's complement).
- SLOT_WIDTH, 16, bclk periods per channel slot. Must be >= DATA_WIDTH; extra bits are zero-padded after the LSB.
- BCLK_DIV, 4, clk cycles per bclk half-period. Must be >= 1.

Ports:
- clk, in, 1, system clock; every register is clocked on its rising edge.
- reset, in, 1, synchronous, active-high.
- enable, in, 1, run request.
- sample_left, in, DATA_WIDTH, left sample.
- sample_right, in, DATA_WIDTH, right sample.
- sample_valid, in, 1, sample pair is available.
- sample_ready, out, 1, one-cycle accept pulse.
- underrun, out, 1, one-cycle pulse when no sample is available at the accept point.
- bclk, out, 1, serial bit clock.
- lrclk, out, 1, word select: 0 = left, 1 = right.
- sdata, out, 1, serial data.

Behaviour:
- Reset (and IDLE state): bclk=0, lrclk=0, sdata=0, sample_ready=0, underrun=0. Divider, bit index, holding and shift registers are cleared. Reset asserted mid-frame aborts the frame the next cycle.
- Divider: div_cnt counts 0..BCLK_DIV-1 in RUN. On wrap, bclk toggles.
  - A falling tick is the cycle where bclk goes 1->0.
  - bit index b (0..2*SLOT_WIDTH-1) advances, and lrclk/sdata update, in the same cycle as the falling tick.
- Frame layout, with W = SLOT_WIDTH:
  - lrclk=0 for b=2W-1 and b=0..W-2; lrclk=1 for b=W-1..2W-2. lrclk therefore leads the data by one bit (I2S delay).
  - sdata at b=0..W-1: left MSB first; bits beyond DATA_WIDTH are 0.
  - sdata at b=W..2W-1: right, same format.
- FSM states:
  - IDLE: outputs low. When enable=1, the next cycle enters RUN with b=2W-1, bclk=0, div_cnt=0, and performs an accept attempt in that entry cycle.
  - RUN: on each falling tick, b advances (wrapping 2W-1 -> 0).
    - Entering b=2W-1: if enable=0, go to IDLE (no accept, outputs low). Otherwise perform an accept attempt.
    - Entering b=0: the holding registers are copied into the output shift register.
- Accept attempt (single cycle):
  - sample_ready=1 that cycle, regardless of sample_valid.
  - If sample_valid=1: the holding registers capture sample_left/sample_right.
  - If sample_valid=0: underrun=1 that cycle and the holding registers take the underrun value (see Optional Feature).
  - sample_valid is sampled only in that cycle; the upstream side must present data combinationally or hold it.
- Frame period: 2*SLOT_WIDTH*2*BCLK_DIV clk cycles.
  - Latency from accept to left MSB on sdata: one bclk period (2*BCLK_DIV clk cycles).
- enable deasserted mid-frame: the current frame completes; stop occurs at the falling tick entering b=2W-1. Re-asserting enable before then cancels the stop.

Optional Feature:
- Macro: AUDIO_SERIAL_TX_HOLD_LAST_EN.
- Defined: on underrun the holding registers keep the previous sample pair (last sample repeats). After reset, the held value is 0.
- Undefined: on underrun the holding registers load 0 (silence).
- underrun pulse behaviour is identical in both builds.

Test Plan (DATA_WIDTH=16, SLOT_WIDTH=16, BCLK_DIV=2 unless noted):
- Reset/idle: reset=1 then enable=0 for 200 cycles -> bclk, lrclk, sdata, sample_ready and underrun all 0 throughout.
- Basic frame: enable=1, sample_valid=1, L=0xA5F0, R=0x0F3C.
  - Required: sample_ready pulses once per 128 clk cycles.
  - Sampled on bclk rising edges, sdata reads 1010010111110000 (lrclk=0) then 0000111100111100 (lrclk=1).
  - lrclk transitions exactly one bclk before each MSB.
- Padding: SLOT_WIDTH=24, L=0x8001 -> left slot reads 1000000000000001 followed by eight 0s; frame is 192 clk cycles.
- Underrun: hold sample_valid=0 for one accept after frame L=0x1234 -> underrun pulses coincident with sample_ready. Next frame sends 0x0000/0x0000, or 0x1234/R with AUDIO_SERIAL_TX_HOLD_LAST_EN defined.
- Stop mid-frame: drop enable at b=5 -> frame completes through b=2W-2; at the next falling tick, outputs go low, no sample_ready occurs, and the FSM is in IDLE.
- Reset mid-frame: assert reset at b=20 -> all outputs 0 on the next clk. Re-enabling gives a fresh accept with the first left MSB 2*BCLK_DIV cycles later.

Source files
------------

// File: rtl/audio_serial_tx.sv
// I2S playback serializer: pulls one stereo pair per frame over valid/ready and
// shifts it out MSB first on sdata with bclk/lrclk generated from clk.
// Optional build macro AUDIO_SERIAL_TX_HOLD_LAST_EN: on underrun, repeat the last
// pair instead of sending silence.
module audio_serial_tx #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned SLOT_WIDTH = 16,
   parameter int unsigned BCLK_DIV   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [DATA_WIDTH-1:0] sample_left,
   input  logic [DATA_WIDTH-1:0] sample_right,
   input  logic                  sample_valid,
   output logic                  sample_ready,
   output logic                  underrun,
   output logic                  bclk,
   output logic                  lrclk,
   output logic                  sdata
);

   localparam int unsigned FrameBits = 2 * SLOT_WIDTH;
   localparam int unsigned BitW      = $clog2(FrameBits);
   localparam int unsigned DivW      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam int unsigned PadBits   = SLOT_WIDTH - DATA_WIDTH;

   localparam logic [BitW-1:0] BitLast   = BitW'(FrameBits - 1);
   // lrclk leads the data by one bit: high from the last left bit to the
   // second-to-last right bit.
   localparam logic [BitW-1:0] BitLrHigh = BitW'(SLOT_WIDTH - 1);
   localparam logic [BitW-1:0] BitLrLow  = BitW'(FrameBits - 2);
   localparam logic [DivW-1:0] DivLast   = DivW'(BCLK_DIV - 1);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e                state_q, state_d;
   logic [DivW-1:0]       div_q, div_d;
   logic [BitW-1:0]       bit_q, bit_d;
   logic                  bclk_q, bclk_d;
   logic                  lrclk_q, lrclk_d;
   logic                  sdata_q, sdata_d;
   logic                  ready_q, ready_d;
   logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d;
   logic [DATA_WIDTH-1:0] hold_r_q, hold_r_d;
   logic [FrameBits-1:0]  shift_q, shift_d;

   logic                  div_wrap;
   logic                  fall_tick;
   logic                  stopping;
   logic [BitW-1:0]       bit_next;
   logic [SLOT_WIDTH-1:0] left_slot;
   logic [SLOT_WIDTH-1:0] right_slot;
   logic [FrameBits-1:0]  frame_load;

   assign div_wrap   = (div_q == DivLast);
   assign fall_tick  = (state_q == StRun) && div_wrap && bclk_q;
   assign bit_next   = (bit_q == BitLast) ? '0 : bit_q + 1'b1;
   // Stop decision is taken only at the tick entering the last bit of the frame.
   assign stopping   = fall_tick && (bit_next == BitLast) && !enable;
   assign left_slot  = SLOT_WIDTH'(hold_l_q) << PadBits;
   assign right_slot = SLOT_WIDTH'(hold_r_q) << PadBits;
   assign frame_load = {left_slot, right_slot};

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (enable) state_d = StRun;
         StRun:   if (stopping) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Datapath next values; everything clears in IDLE and on stop.
   always_comb begin
      div_d    = '0;
      bclk_d   = 1'b0;
      bit_d    = '0;
      lrclk_d  = 1'b0;
      sdata_d  = 1'b0;
      ready_d  = 1'b0;
      hold_l_d = '0;
      hold_r_d = '0;
      shift_d  = '0;
      if (state_q == StIdle) begin
         if (enable) begin
            bit_d   = BitLast;
            ready_d = 1'b1;
         end
      end else if (!stopping) begin
         div_d    = div_wrap ? '0 : div_q + 1'b1;
         bclk_d   = div_wrap ? ~bclk_q : bclk_q;
         bit_d    = bit_q;
         lrclk_d  = lrclk_q;
         sdata_d  = sdata_q;
         hold_l_d = hold_l_q;
         hold_r_d = hold_r_q;
         shift_d  = shift_q;
         if (fall_tick) begin
            bit_d   = bit_next;
            lrclk_d = (bit_next >= BitLrHigh) && (bit_next <= BitLrLow);
            if (bit_next == '0) begin
               sdata_d = frame_load[FrameBits-1];
               shift_d = frame_load << 1;
            end else begin
               sdata_d = shift_q[FrameBits-1];
               shift_d = shift_q << 1;
            end
            if (bit_next == BitLast) ready_d = 1'b1;
         end
         if (ready_q) begin
            if (sample_valid) begin
               hold_l_d = sample_left;
               hold_r_d = sample_right;
            end else begin
`ifdef AUDIO_SERIAL_TX_HOLD_LAST_EN
               hold_l_d = hold_l_q;
               hold_r_d = hold_r_q;
`else
               hold_l_d = '0;
               hold_r_d = '0;
`endif
            end
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_q    <= '0;
         bclk_q   <= 1'b0;
         bit_q    <= '0;
         lrclk_q  <= 1'b0;
         sdata_q  <= 1'b0;
         ready_q  <= 1'b0;
         hold_l_q <= '0;
         hold_r_q <= '0;
         shift_q  <= '0;
      end else begin
         div_q    <= div_d;
         bclk_q   <= bclk_d;
         bit_q    <= bit_d;
         lrclk_q  <= lrclk_d;
         sdata_q  <= sdata_d;
         ready_q  <= ready_d;
         hold_l_q <= hold_l_d;
         hold_r_q <= hold_r_d;
         shift_q  <= shift_d;
      end
   end

   // Outputs; underrun flags an accept cycle with no sample offered.
   always_comb begin
      sample_ready = ready_q;
      underrun     = ready_q & ~sample_valid;
      bclk         = bclk_q;
      lrclk        = lrclk_q;
      sdata        = sdata_q;
   end

endmodule
